// File: rtl/miriscv_rvfi_pkg.sv
// Shared RVFI retirement record type and helpers for the serializer slice.
package miriscv_rvfi_pkg;

  typedef struct packed {
    logic [63:0] order;
    logic [31:0] insn;
    logic        trap;
    logic        intr;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
  } rvfi_rec_t;

  localparam int unsigned REC_W = 303;

  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned c;
    c = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      c = c + 32'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/miriscv_rvfi_compact.sv
// Maps per-slot retire valids to compacted FIFO write offsets and a total count.
module miriscv_rvfi_compact
  import miriscv_rvfi_pkg::*;
#(
  parameter  int unsigned NRET  = 2,
  localparam int unsigned OFF_W = $clog2(NRET + 1)
) (
  input  logic [NRET-1:0]            valid,
  output logic [NRET-1:0][OFF_W-1:0] offs,
  output logic [OFF_W-1:0]           n
);

  logic [OFF_W-1:0] acc;

  // Each slot's offset is the number of valid slots below it (exclusive prefix sum).
  always_comb begin
    offs = '0;
    acc  = '0;
    for (int unsigned i = 0; i < NRET; i++) begin
      offs[i] = acc;
      acc     = acc + OFF_W'(valid[i]);
    end
    n = OFF_W'(popcount(32'(valid)));
  end

endmodule

// File: rtl/miriscv_rvfi_serializer.sv
// Buffers multi-slot RVFI retirements in program order and emits one record per
// valid/ready handshake, with overflow accounting and an order continuity check.
module miriscv_rvfi_serializer
  import miriscv_rvfi_pkg::*;
#(
  parameter  int unsigned NRET  = 2,
  parameter  int unsigned DEPTH = 8,
  parameter  int unsigned CNT_W = 16,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned LW    = AW + 1,
  localparam int unsigned OFF_W = $clog2(NRET + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [NRET-1:0]       in_valid,
  input  logic [NRET*REC_W-1:0] in_rec,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [REC_W-1:0]      out_rec,
  output logic [LW-1:0]         level,
  output logic                  overflow,
  output logic [CNT_W-1:0]      drop_cnt,
  output logic                  order_err
);

  rvfi_rec_t mem [DEPTH];

  logic [LW-1:0]              wptr;
  logic [LW-1:0]              rptr;
  logic [NRET-1:0][OFF_W-1:0] offs;
  logic [OFF_W-1:0]           n;
  rvfi_rec_t                  head;
  logic                       any_valid;
  logic                       push_ok;
  logic                       drop;
  logic                       pop;
  logic [CNT_W:0]             drop_sum;
  logic [63:0]                exp_order;
  logic                       exp_valid;

  miriscv_rvfi_compact #(.NRET(NRET)) u_compact (
    .valid (in_valid),
    .offs  (offs),
    .n     (n)
  );

  assign level     = wptr - rptr;
  assign in_ready  = (LW'(DEPTH) - level) >= LW'(NRET);
  assign out_valid = (level != '0);
  assign head      = mem[rptr[AW-1:0]];
  assign out_rec   = out_valid ? head : '0;

  assign any_valid = |in_valid;
  assign push_ok   = any_valid && in_ready;
  assign drop      = any_valid && !in_ready;
  assign pop       = out_valid && out_ready;
  assign drop_sum  = {1'b0, drop_cnt} + (CNT_W + 1)'(n);

  always_ff @(posedge clk) begin
    if (!rst && !flush && push_ok) begin
      for (int unsigned i = 0; i < NRET; i++) begin
        if (in_valid[i]) begin
          mem[wptr[AW-1:0] + AW'(offs[i])] <= in_rec[i*REC_W +: REC_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      overflow  <= 1'b0;
      drop_cnt  <= '0;
      order_err <= 1'b0;
      exp_order <= '0;
      exp_valid <= 1'b0;
    end else if (flush) begin
      // Pushes and pops in the flush cycle are discarded without drop accounting or checking.
      wptr      <= '0;
      rptr      <= '0;
      exp_valid <= 1'b0;
    end else begin
      if (push_ok) begin
        wptr <= wptr + LW'(n);
      end
      if (drop) begin
        overflow <= 1'b1;
        drop_cnt <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
        if (exp_valid && head.order != exp_order) begin
          order_err <= 1'b1;
        end
        exp_order <= head.order + 64'd1;
        exp_valid <= 1'b1;
      end
    end
  end

endmodule
